// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader: host-side writer for the CPU data memory.
//   Accepts a stream of DATA_W-bit words and writes them to sequential
//   addresses starting at 0. It stops after s_last or after DEPTH words.
//   It then releases the CPU (cpu_run) and counts cycles until the CPU
//   completion flag rises. On that edge it reports done.
// Optional feature: LOADER_TIMEOUT_EN enables a run watchdog. It aborts the
//   run after TIMEOUT_CYCLES cycles and raises the sticky timeout output.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, cfg_cnt            start pulse (IDLE/DONE only) and op count to latch
//   s_valid/s_data/s_last     input word stream; s_ready is high in LOAD only
//   mem_wr_en/addr/data       registered memory write port (1-cycle latency)
//   cpu_run, cnt_out          CPU release (rst_n_cpu) and latched op count
//   cpu_flag                  CPU operation-finished flag
//   busy, done, ovf           status: LOAD/RUN, run finished, image overflowed
//   run_cycles                cycles from cpu_run rise to flag edge (saturating)
//   timeout                   watchdog expired (0 unless LOADER_TIMEOUT_EN)
module cpu_mem_loader #(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned DATA_W         = 4,
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned CNT_W          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_cnt,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              cpu_run,
    output logic [CNT_W-1:0]  cnt_out,
    input  logic              cpu_flag,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [15:0]       run_cycles,
    output logic              timeout
);

    localparam int unsigned RUN_W = 16;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [RUN_W-1:0]  RUN_MAX   = {RUN_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                cpu_run_q, cpu_run_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [RUN_W-1:0]    run_cycles_q, run_cycles_d;
    logic                timeout_q, timeout_d;
    logic                flag_q, flag_d;
    logic                flag_rise;

    // cpu_flag is sampled every cycle. This flop therefore already holds the
    // flag value from the last LOAD cycle when RUN starts, so a flag that is
    // high at RUN entry does not count as an edge.
    assign flag_rise = cpu_flag & ~flag_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cpu_run_q    <= 1'b0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            run_cycles_q <= '0;
            timeout_q    <= 1'b0;
            flag_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_run_q    <= cpu_run_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            run_cycles_q <= run_cycles_d;
            timeout_q    <= timeout_d;
            flag_q       <= flag_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cpu_run_d    = cpu_run_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        ovf_d        = ovf_q;
        run_cycles_d = run_cycles_q;
        timeout_d    = timeout_q;
        flag_d       = cpu_flag;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d        = cfg_cnt;
                    addr_d       = '0;
                    done_d       = 1'b0;
                    ovf_d        = 1'b0;
                    timeout_d    = 1'b0;
                    run_cycles_d = '0;
                    cpu_run_d    = 1'b0;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = s_data;
                    addr_d    = addr_q + 1'b1;
                    // The CPU is released together with the final strobe, so
                    // the last write lands before the CPU leaves reset.
                    if (s_last || (addr_q == LAST_ADDR)) begin
                        if (!s_last) begin
                            ovf_d = 1'b1;
                        end
                        cpu_run_d = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (flag_rise) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    if (run_cycles_q != RUN_MAX) begin
                        run_cycles_d = run_cycles_q + 1'b1;
                    end
`ifdef LOADER_TIMEOUT_EN
                    if (32'(run_cycles_d) >= 32'(TIMEOUT_CYCLES)) begin
                        timeout_d = 1'b1;
                        cpu_run_d = 1'b0;
                        done_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifndef LOADER_TIMEOUT_EN
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^32'(TIMEOUT_CYCLES);
`endif

    assign s_ready     = (state_q == ST_LOAD);
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign cpu_run     = cpu_run_q;
    assign cnt_out     = cnt_q;
    assign done        = done_q;
    assign ovf         = ovf_q;
    assign run_cycles  = run_cycles_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Directed testbench for cpu_mem_loader (default build, watchdog disabled).
module tb_cpu_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  cfg_cnt;
    logic        s_valid;
    logic [3:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        mem_wr_en;
    logic [4:0]  mem_wr_addr;
    logic [3:0]  mem_wr_data;
    logic        cpu_run;
    logic [4:0]  cnt_out;
    logic        cpu_flag;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] run_cycles;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    cpu_mem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_cnt    (cfg_cnt),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .cpu_run    (cpu_run),
        .cnt_out    (cnt_out),
        .cpu_flag   (cpu_flag),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .run_cycles (run_cycles),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_en"},   32'(mem_wr_en),   0);
        check({tag, "_wr_addr"}, 32'(mem_wr_addr), 0);
        check({tag, "_wr_data"}, 32'(mem_wr_data), 0);
        check({tag, "_cpu_run"}, 32'(cpu_run),     0);
        check({tag, "_cnt_out"}, 32'(cnt_out),     0);
        check({tag, "_busy"},    32'(busy),        0);
        check({tag, "_done"},    32'(done),        0);
        check({tag, "_ovf"},     32'(ovf),         0);
        check({tag, "_runcyc"},  32'(run_cycles),  0);
        check({tag, "_s_ready"}, 32'(s_ready),     0);
        check({tag, "_timeout"}, 32'(timeout),     0);
    endtask

    // Present one word. The write strobe must follow on the next cycle.
    task automatic send_word(input int idx, input logic [3:0] data, input logic last);
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        step();
        check($sformatf("wr_en_%0d", idx),   32'(mem_wr_en),   1);
        check($sformatf("wr_addr_%0d", idx), 32'(mem_wr_addr), 32'(idx));
        check($sformatf("wr_data_%0d", idx), 32'(mem_wr_data), 32'(data));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] cnt);
        start   = 1'b1;
        cfg_cnt = cnt;
        step();
        start   = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        cfg_cnt  = '0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        cpu_flag = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        // Reset asserted in the middle of a load
        do_start(5'd3);
        check("t1_s_ready", 32'(s_ready), 1);
        check("t1_cnt_out", 32'(cnt_out), 3);
        for (int i = 0; i < 5; i++) send_word(i, 4'(i + 9), 1'b0);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        step();
        rst = 1'b0;
        step();

        // 24-word image; s_valid is also high on the start cycle and must be ignored
        start   = 1'b1;
        cfg_cnt = 5'd8;
        s_valid = 1'b1;
        s_data  = 4'hA;
        step();
        start = 1'b0;
        check("t2_start_no_wr", 32'(mem_wr_en), 0);
        check("t2_s_ready",     32'(s_ready),   1);
        check("t2_cnt_out",     32'(cnt_out),   8);
        check("t2_busy",        32'(busy),      1);
        for (int i = 0; i < 24; i++) begin
            if (i == 23) check("t2_run_before_last", 32'(cpu_run), 0);
            send_word(i, 4'(i % 16), (i == 23));
        end
        check("t2_cpu_run_with_last", 32'(cpu_run), 1);
        check("t2_ovf",      32'(ovf),     0);
        check("t2_s_ready",  32'(s_ready), 0);
        check("t2_cnt_out8", 32'(cnt_out), 8);

        // Flag rises 37 cycles after cpu_run rises
        for (int i = 0; i < 37; i++) step();
        check("t3_not_done", 32'(done), 0);
        cpu_flag = 1'b1;
        step();
        check("t3_done",       32'(done),       1);
        check("t3_run_cycles", 32'(run_cycles), 37);
        check("t3_busy",       32'(busy),       0);
        check("t3_cpu_run",    32'(cpu_run),    1);
        step();
        step();
        check("t3_run_hold",  32'(run_cycles), 37);
        check("t3_done_hold", 32'(done),       1);
        cpu_flag = 1'b0;
        step();

        // Restart from DONE drops cpu_run; 33 words with no s_last overflow
        do_start(5'd17);
        check("t4_cpu_run_drop", 32'(cpu_run),    0);
        check("t4_done_clr",     32'(done),       0);
        check("t4_run_clr",      32'(run_cycles), 0);
        check("t4_cnt_out",      32'(cnt_out),    17);
        for (int i = 0; i < 32; i++) send_word(i, 4'(15 - (i % 16)), 1'b0);
        check("t4_ovf",     32'(ovf),     1);
        check("t4_s_ready", 32'(s_ready), 0);
        check("t4_cpu_run", 32'(cpu_run), 1);
        s_valid = 1'b1;
        s_data  = 4'h5;
        step();
        check("t4_word33_rejected", 32'(mem_wr_en), 0);
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        cpu_flag = 1'b1;
        step();
        check("t4_done",       32'(done),       1);
        check("t4_run_cycles", 32'(run_cycles), 5);
        check("t4_ovf_hold",   32'(ovf),        1);
        cpu_flag = 1'b0;
        step();

        // Flag already high at RUN entry: only the later true edge counts
        do_start(5'd2);
        check("t5_ovf_clr", 32'(ovf), 0);
        send_word(0, 4'h1, 1'b0);
        cpu_flag = 1'b1;
        send_word(1, 4'h2, 1'b1);
        check("t5_cpu_run", 32'(cpu_run), 1);
        for (int i = 0; i < 3; i++) step();
        check("t5_no_done_high", 32'(done), 0);
        cpu_flag = 1'b0;
        start    = 1'b1;
        cfg_cnt  = 5'd1;
        step();
        start = 1'b0;
        check("t5_start_ignored", 32'(cnt_out), 2);
        check("t5_still_busy",    32'(busy),    1);
        for (int i = 0; i < 9; i++) step();
        check("t5_no_done_low", 32'(done), 0);
        cpu_flag = 1'b1;
        step();
        check("t5_done",       32'(done),       1);
        check("t5_run_cycles", 32'(run_cycles), 13);
        check("t5_timeout",    32'(timeout),    0);
        cpu_flag = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem_loader.md
Name: cpu_mem_loader

Overview:
- Host-side writer for the CPU data memory: accepts a stream of 4-bit words, writes them to sequential addresses of the 32x4 data memory, then releases the CPU and waits for its completion flag.
- Companion to the result read-back path. It fills memory before a run, launches the run and reports when the result is ready to read.
- Sits between the host/stimulus interface and cpu_top's memory write port and run/flag pins.
- Also measures run duration in clock cycles.

Parameters:
- ADDR_W, 5, memory address width
- DATA_W, 4, memory word width
- DEPTH, 32, number of memory words; load stops after DEPTH words
- CNT_W, 5, width of the operation count passed to the CPU
- TIMEOUT_CYCLES, 50000, watchdog limit in cycles (used only with LOADER_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a load/run; honoured only in IDLE or DONE
- cfg_cnt  in  CNT_W  operation count; latched on accepted start
- s_valid  in  1  stream word valid
- s_data  in  DATA_W  stream word
- s_last  in  1  marks final word of image
- s_ready  out  1  loader can accept a word
- mem_wr_en  out  1  memory write strobe
- mem_wr_addr  out  ADDR_W  memory write address
- mem_wr_data  out  DATA_W  memory write data
- cpu_run  out  1  high = CPU out of reset (drives cpu_top rst_n_cpu)
- cnt_out  out  CNT_W  latched count to CPU cnt input
- cpu_flag  in  1  CPU operation-finished flag
- busy  out  1  high in LOAD or RUN
- done  out  1  run finished; results valid
- ovf  out  1  sticky: DEPTH words loaded without s_last
- run_cycles  out  16  cycles from cpu_run rise to flag edge, saturating at 0xFFFF
- timeout  out  1  watchdog expired (LOADER_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset (async, any state): state=IDLE; every output 0, including cnt_out, run_cycles, mem_wr_*, ovf and timeout. Internal address counter 0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE / DONE, start=1:
  - latch cfg_cnt into cnt_out; address=0; clear done, ovf, timeout and run_cycles; cpu_run=0.
  - go to LOAD.
  - start in LOAD or RUN is ignored.
- LOAD:
  - s_ready=1 (combinational from state).
  - Handshake is s_valid&&s_ready. On a handshake, next cycle mem_wr_en=1, mem_wr_addr=address, mem_wr_data=s_data (registered, 1-cycle latency); address increments.
  - mem_wr_en is 0 in cycles with no handshake.
  - Exit on a handshake with s_last=1, or on the handshake at address DEPTH-1. In the latter case, if s_last=0, set ovf=1.
  - Next state is RUN. Further stream words are not accepted (s_ready=0 outside LOAD).
- RUN entry:
  - cpu_run rises on the cycle the final write strobe is presented (write lands before the CPU leaves reset).
  - flag edge register is loaded with the current cpu_flag, so only a true 0->1 transition counts.
- RUN:
  - run_cycles increments every cycle, saturating.
  - On a cpu_flag rising edge: done=1, state=DONE. run_cycles freezes; the edge cycle itself is not counted.
- DONE:
  - cpu_run stays 1 so memory/CPU hold results for read-back.
  - done, run_cycles and ovf are held.
  - start re-enters LOAD and drops cpu_run to 0 in that same transition.
- busy = (state==LOAD)||(state==RUN).
- Simultaneous events:
  - s_valid arriving on the start cycle is not accepted (s_ready becomes 1 the following cycle).
  - cpu_flag edge on the RUN entry cycle is ignored (edge register preload).
- Address wraps never occur; the load is bounded at DEPTH.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN
- Defined:
  - In RUN, when run_cycles reaches TIMEOUT_CYCLES without a flag edge: timeout=1 (sticky), cpu_run=0, done=0, state=IDLE.
  - Cleared by the next accepted start or by reset.
- Undefined: no watchdog; RUN waits indefinitely; timeout tied 0.

Test Plan:
- Reset mid-LOAD after 5 words -> all outputs 0 immediately, state IDLE, cpu_run 0; the next start begins again at address 0.
- start with cfg_cnt=8, stream 24 words 0..15,0..7 with s_last on word 24 -> 24 writes at addresses 0..23 with matching data, ovf=0; cpu_run rises with the final strobe; cnt_out=8.
- In RUN, raise cpu_flag 37 cycles after cpu_run rises -> done=1, run_cycles=37, busy=0, cpu_run held 1.
- Stream 33 words with no s_last -> 32 writes (0..31), ovf=1, the 33rd word not accepted (s_ready=0); the run proceeds normally.
- cpu_flag held high at RUN entry, drop after 3 cycles, rise after 10 more -> done only on the later edge; run_cycles=13.
- With LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=100, no flag -> at cycle 100 timeout=1, cpu_run=0, state IDLE; a following start clears timeout.
